// File: rtl/rs232_tx_arbiter_if.sv
// Requester-side and transmitter-side signals of the RS232 TX arbiter.
// master: producers plus transmitter status; slave: the arbiter itself.
interface rs232_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   ReqValid;
    logic [8*NUM_REQ-1:0] ReqData;
    logic [NUM_REQ-1:0]   ReqLast;
    logic [NUM_REQ-1:0]   ReqReady;
    logic [NUM_REQ-1:0]   Grant;
    logic                 Active;
    logic [7:0]           WriteLine;
    logic                 Send;
    logic                 TxBusy;

    modport master (
        output ReqValid, ReqData, ReqLast, TxBusy,
        input  ReqReady, Grant, Active, WriteLine, Send
    );

    modport slave (
        input  ReqValid, ReqData, ReqLast, TxBusy,
        output ReqReady, Grant, Active, WriteLine, Send
    );
endinterface

// File: rtl/rs232_tx_arbiter.sv
// Packet-granular round-robin sharing of one RS232 byte transmitter.
// Define RS232_ARB_TAG_EN to prefix each packet with a channel tag byte.
module rs232_tx_arbiter #(
    parameter int         NUM_REQ      = 4,
    parameter int         BUSY_TIMEOUT = 16,
    parameter logic [7:0] TAG_BASE     = 8'hF0
) (
    input logic               Clock,
    input logic               Reset_n,
    rs232_tx_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
`ifdef RS232_ARB_TAG_EN
        TAG     = 3'd1,
`endif
        LOAD    = 3'd2,
        SEND    = 3'd3,
        WAIT_HI = 3'd4,
        WAIT_LO = 3'd5
    } state_t;

    state_t             state, state_n;
    logic [NUM_REQ-1:0] grant, grant_n;
    logic [IDX_W-1:0]   gidx, gidx_n;
    logic [IDX_W-1:0]   ptr, ptr_n;
    logic [7:0]         wline, wline_n;
    logic               last, last_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               found;
    logic [IDX_W-1:0]   pick;
    logic               sel_valid;
    logic               sel_last;
    logic [7:0]         sel_data;
    logic               accept;

`ifdef RS232_ARB_TAG_EN
    logic tag_phase, tag_phase_n;
`else
    logic unused_tag_base;
    assign unused_tag_base = ^TAG_BASE;
`endif

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    // Search starts one past the last packet owner so every requester gets a turn.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!found && bus.ReqValid[IDX_W'((int'(ptr) + i) % NUM_REQ)]) begin
                found = 1'b1;
                pick  = IDX_W'((int'(ptr) + i) % NUM_REQ);
            end
        end
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gidx == IDX_W'(i)) begin
                sel_valid = bus.ReqValid[i];
                sel_last  = bus.ReqLast[i];
                sel_data  = bus.ReqData[8*i +: 8];
            end
        end
    end

    assign accept        = (state == LOAD) && sel_valid && !bus.TxBusy;
    assign bus.ReqReady  = accept ? grant : '0;
    assign bus.Grant     = grant;
    assign bus.Active    = (state != IDLE);
    assign bus.WriteLine = wline;
    assign bus.Send      = (state == SEND);

    always_comb begin
        state_n = state;
        grant_n = grant;
        gidx_n  = gidx;
        ptr_n   = ptr;
        wline_n = wline;
        last_n  = last;
        cnt_n   = cnt;
`ifdef RS232_ARB_TAG_EN
        tag_phase_n = tag_phase;
`endif
        case (state)
            IDLE: begin
                if (found) begin
                    gidx_n  = pick;
                    grant_n = NUM_REQ'(1) << pick;
`ifdef RS232_ARB_TAG_EN
                    state_n = TAG;
`else
                    state_n = LOAD;
`endif
                end
            end
`ifdef RS232_ARB_TAG_EN
            TAG: begin
                wline_n     = {TAG_BASE[7:4], 4'(gidx)};
                tag_phase_n = 1'b1;
                state_n     = SEND;
            end
`endif
            LOAD: begin
                if (accept) begin
                    wline_n = sel_data;
                    last_n  = sel_last;
                    state_n = SEND;
                end
            end
            SEND: begin
                cnt_n   = '0;
                state_n = WAIT_HI;
            end
            // A transmitter that never reports busy is released by the timeout.
            WAIT_HI: begin
                if (bus.TxBusy || cnt == CNT_LAST) begin
                    state_n = WAIT_LO;
                end else begin
                    cnt_n = sat_inc(cnt);
                end
            end
            WAIT_LO: begin
                if (!bus.TxBusy) begin
`ifdef RS232_ARB_TAG_EN
                    if (tag_phase) begin
                        tag_phase_n = 1'b0;
                        state_n     = LOAD;
                    end else
`endif
                    if (last) begin
                        ptr_n   = gidx;
                        grant_n = '0;
                        state_n = IDLE;
                    end else begin
                        state_n = LOAD;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
            grant <= '0;
            gidx  <= '0;
            ptr   <= IDX_W'(NUM_REQ - 1);
            wline <= 8'h00;
            last  <= 1'b0;
            cnt   <= '0;
`ifdef RS232_ARB_TAG_EN
            tag_phase <= 1'b0;
`endif
        end else begin
            state <= state_n;
            grant <= grant_n;
            gidx  <= gidx_n;
            ptr   <= ptr_n;
            wline <= wline_n;
            last  <= last_n;
            cnt   <= cnt_n;
`ifdef RS232_ARB_TAG_EN
            tag_phase <= tag_phase_n;
`endif
        end
    end
endmodule

// File: tb/tb_rs232_tx_arbiter.sv
// Scoreboard bench for rs232_tx_arbiter: requester queues, a TxBusy model,
// and an expected {Grant, WriteLine} queue checked on every Send pulse.
module tb_rs232_tx_arbiter;
    localparam int         NUM_REQ      = 4;
    localparam int         BUSY_TIMEOUT = 16;
    localparam logic [7:0] TAG_BASE     = 8'hF0;
`ifdef RS232_ARB_TAG_EN
    localparam int TAG_EN = 1;
`else
    localparam int TAG_EN = 0;
`endif

    logic Clock = 1'b0;
    logic Reset_n;

    rs232_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    rs232_tx_arbiter #(
        .NUM_REQ(NUM_REQ),
        .BUSY_TIMEOUT(BUSY_TIMEOUT),
        .TAG_BASE(TAG_BASE)
    ) dut (
        .Clock(Clock),
        .Reset_n(Reset_n),
        .bus(bus)
    );

    initial forever #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int send_total = 0;
    int rise_cyc = 0;
    int busy_cnt = 0;
    bit busy_mode = 1'b0;
    int ready_cnt [NUM_REQ];
    logic [8:0] rq [NUM_REQ][$];
    logic [NUM_REQ+7:0] expq [$];
    int send_cyc [$];

    // Transmitter model and scoreboard: TxBusy high for 10 cycles after Send
    // (busy_mode=0) or tied low (busy_mode=1).
    initial begin
        logic [NUM_REQ+7:0] e;
        bus.TxBusy = 1'b0;
        forever begin
            @(negedge Clock);
            cyc++;
            if (bus.Send === 1'b1) begin
                send_total++;
                send_cyc.push_back(cyc);
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL send_unexpected: Grant=%b WriteLine=%h, required no Send", bus.Grant, bus.WriteLine);
                end else begin
                    e = expq.pop_front();
                    if ({bus.Grant, bus.WriteLine} !== e) begin
                        errors++;
                        $display("FAIL send_data: Grant=%b WriteLine=%h, required Grant=%b WriteLine=%h",
                                 bus.Grant, bus.WriteLine, e[NUM_REQ+7:8], e[7:0]);
                    end
                end
                busy_cnt = (busy_mode == 1'b0) ? 10 : 0;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
            end
            bus.TxBusy = (busy_cnt != 0);
        end
    end

    // Requester model: presents queue heads, pops after an accepted handshake.
    initial begin
        logic [NUM_REQ-1:0]   take, v, prev_v;
        logic [NUM_REQ-1:0]   l;
        logic [8*NUM_REQ-1:0] d;
        take = '0;
        prev_v = '0;
        forever begin
            @(negedge Clock);
            for (int i = 0; i < NUM_REQ; i++)
                if (take[i] && rq[i].size() > 0) void'(rq[i].pop_front());
            v = '0; l = '0; d = '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (rq[i].size() > 0) begin
                    v[i] = 1'b1;
                    l[i] = rq[i][0][8];
                    d[8*i +: 8] = rq[i][0][7:0];
                end
            end
            bus.ReqValid = v;
            bus.ReqLast  = l;
            bus.ReqData  = d;
            #1;
            if ((v & ~prev_v) != '0) rise_cyc = cyc;
            prev_v = v;
            take = bus.ReqValid & bus.ReqReady;
            for (int i = 0; i < NUM_REQ; i++)
                if (take[i]) ready_cnt[i]++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic push_exp(input int i, input logic [7:0] d, input bit first);
        logic [NUM_REQ-1:0] g;
        g = NUM_REQ'(1) << i;
        if (first && TAG_EN == 1) expq.push_back({g, TAG_BASE[7:4], 4'(i)});
        expq.push_back({g, d});
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (expq.size() != 0 && n < 2000) begin
            @(negedge Clock); #2;
            n++;
        end
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d sends outstanding, required 0", name, expq.size());
            expq.delete();
        end
        repeat (25) @(negedge Clock);
        #2;
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if (bus.Grant !== '0) begin errors++; $display("FAIL %s_grant: got %b, required 0", name, bus.Grant); end
        checks++;
        if (bus.ReqReady !== '0) begin errors++; $display("FAIL %s_ready: got %b, required 0", name, bus.ReqReady); end
        checks++;
        if (bus.Send !== 1'b0) begin errors++; $display("FAIL %s_send: got %b, required 0", name, bus.Send); end
        checks++;
        if (bus.WriteLine !== 8'h00) begin errors++; $display("FAIL %s_writeline: got %h, required 00", name, bus.WriteLine); end
        checks++;
        if (bus.Active !== 1'b0) begin errors++; $display("FAIL %s_active: got %b, required 0", name, bus.Active); end
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        repeat (3) @(negedge Clock);
        #2;
        check_idle_outputs("reset");
        @(posedge Clock); #2;
        Reset_n = 1'b1;
    endtask

    task automatic test_single_packet();
        int s0, r0, base, lat;
        @(posedge Clock); #2;
        s0 = send_total; r0 = ready_cnt[0]; base = send_cyc.size();
        rq[0].push_back({1'b0, 8'h41});
        rq[0].push_back({1'b1, 8'h42});
        push_exp(0, 8'h41, 1'b1);
        push_exp(0, 8'h42, 1'b0);
        wait_drain("single");
        lat = (send_cyc.size() > base) ? send_cyc[base] - rise_cyc : -1;
        checks++;
        if (lat != 2) begin errors++; $display("FAIL single_latency: got %0d cycles, required 2", lat); end
        checks++;
        if (send_total - s0 != 2 + TAG_EN) begin
            errors++; $display("FAIL single_sends: got %0d, required %0d", send_total - s0, 2 + TAG_EN);
        end
        checks++;
        if (ready_cnt[0] - r0 != 2) begin
            errors++; $display("FAIL single_ready0: got %0d pulses, required 2", ready_cnt[0] - r0);
        end
        checks++;
        if (bus.Grant !== '0) begin errors++; $display("FAIL single_grant: got %b, required 0", bus.Grant); end
        checks++;
        if (bus.Active !== 1'b0) begin errors++; $display("FAIL single_active: got %b, required 0", bus.Active); end
    endtask

    task automatic test_round_robin();
        int r0 [NUM_REQ];
        int bad;
        @(posedge Clock); #2;
        Reset_n = 1'b0;
        repeat (2) @(negedge Clock);
        @(posedge Clock); #2;
        Reset_n = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            r0[i] = ready_cnt[i];
            rq[i].push_back({1'b1, 8'hA0 + 8'(i)});
            rq[i].push_back({1'b1, 8'hB0 + 8'(i)});
        end
        for (int i = 0; i < NUM_REQ; i++) push_exp(i, 8'hA0 + 8'(i), 1'b1);
        for (int i = 0; i < NUM_REQ; i++) push_exp(i, 8'hB0 + 8'(i), 1'b1);
        wait_drain("rr");
        bad = 0;
        for (int i = 0; i < NUM_REQ; i++) if (ready_cnt[i] - r0[i] != 2) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL rr_ready_counts: %0d requesters off, required 0", bad); end
    endtask

    task automatic test_packet_lock();
        int n0, n, s0, bad;
        logic [NUM_REQ-1:0] g1;
        g1 = NUM_REQ'(2);
        @(posedge Clock); #2;
        rq[1].push_back({1'b0, 8'hC1});
        rq[2].push_back({1'b1, 8'hD0});
        push_exp(1, 8'hC1, 1'b1);
        push_exp(1, 8'hC2, 1'b0);
        push_exp(2, 8'hD0, 1'b1);
        n0 = expq.size();
        n = 0;
        while (expq.size() > n0 - 1 - TAG_EN && n < 500) begin
            @(negedge Clock); #2;
            n++;
        end
        checks++;
        if (expq.size() != n0 - 1 - TAG_EN) begin
            errors++; $display("FAIL lock_first_byte: %0d outstanding, required %0d", expq.size(), n0 - 1 - TAG_EN);
        end
        s0 = send_total;
        bad = 0;
        repeat (20) begin
            @(negedge Clock); #2;
            if (bus.Grant !== g1) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL lock_grant: %0d cycles not %b, required 0", bad, g1); end
        checks++;
        if (send_total != s0) begin errors++; $display("FAIL lock_nosend: got %0d sends, required 0", send_total - s0); end
        rq[1].push_back({1'b1, 8'hC2});
        wait_drain("lock");
    endtask

    task automatic test_timeout();
        int base, bad;
        @(posedge Clock); #2;
        busy_mode = 1'b1;
        base = send_cyc.size();
        rq[3].push_back({1'b0, 8'h5A});
        rq[3].push_back({1'b1, 8'hA5});
        push_exp(3, 8'h5A, 1'b1);
        push_exp(3, 8'hA5, 1'b0);
        wait_drain("timeout");
        busy_mode = 1'b0;
        checks++;
        if (send_cyc.size() - base != 2 + TAG_EN) begin
            errors++; $display("FAIL timeout_sends: got %0d, required %0d", send_cyc.size() - base, 2 + TAG_EN);
        end
        bad = 0;
        for (int k = base + 1; k < send_cyc.size(); k++)
            if (send_cyc[k] - send_cyc[k-1] != BUSY_TIMEOUT + 3) bad++;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL timeout_spacing: %0d gaps wrong, required all %0d", bad, BUSY_TIMEOUT + 3);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        @(posedge Clock); #2;
        rq[2].push_back({1'b0, 8'hE0});
        rq[2].push_back({1'b1, 8'hE1});
        push_exp(2, 8'hE0, 1'b1);
        n = 0;
        while (expq.size() != 0 && n < 500) begin
            @(negedge Clock); #2;
            n++;
        end
        repeat (4) @(negedge Clock);
        #2;
        Reset_n = 1'b0;
        #1;
        check_idle_outputs("midreset");
        rq[2].delete();
        expq.delete();
        repeat (12) @(negedge Clock);
        @(posedge Clock); #2;
        Reset_n = 1'b1;
        rq[3].push_back({1'b1, 8'hF3});
        rq[1].push_back({1'b1, 8'h71});
        push_exp(1, 8'h71, 1'b1);
        push_exp(3, 8'hF3, 1'b1);
        wait_drain("postreset");
    endtask

`ifdef RS232_ARB_TAG_EN
    task automatic test_tag();
        int s0, r0;
        @(posedge Clock); #2;
        s0 = send_total; r0 = ready_cnt[2];
        rq[2].push_back({1'b1, 8'h55});
        push_exp(2, 8'h55, 1'b1);
        wait_drain("tag");
        checks++;
        if (send_total - s0 != 2) begin errors++; $display("FAIL tag_sends: got %0d, required 2", send_total - s0); end
        checks++;
        if (ready_cnt[2] - r0 != 1) begin errors++; $display("FAIL tag_ready2: got %0d, required 1", ready_cnt[2] - r0); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_packet();
        test_round_robin();
        test_packet_lock();
        test_timeout();
        test_reset_mid();
`ifdef RS232_ARB_TAG_EN
        test_tag();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
